// File: rtl/scan_result_collector_if.sv
// Handshake and group-vector bundle between the group array,
// the scan result collector and the sequencer.
interface scan_result_collector_if #(
  parameter int NUM_GROUPS     = 32,
  parameter int GROUP_ADR_BITS = 5
);
  logic                      scanStart;
  logic [2*NUM_GROUPS-1:0]   grpRslt;
  logic [NUM_GROUPS-1:0]     overTgt;
  logic [NUM_GROUPS-1:0]     stopI;
  logic [NUM_GROUPS-1:0]     rowFullI;
  logic                      rsltValid;
  logic                      rsltReady;
  logic [GROUP_ADR_BITS-1:0] rsltIndex;
  logic                      rsltFound;
  logic                      rsltEnd;
  logic                      rowFullO;
  logic                      busy;
  logic                      overrun;

  modport master (
    output scanStart, grpRslt, overTgt, stopI, rowFullI, rsltReady,
    input  rsltValid, rsltIndex, rsltFound, rsltEnd, rowFullO,
    input  busy, overrun
  );

  modport slave (
    input  scanStart, grpRslt, overTgt, stopI, rowFullI, rsltReady,
    output rsltValid, rsltIndex, rsltFound, rsltEnd, rowFullO,
    output busy, overrun
  );
endinterface

// File: rtl/scan_result_collector.sv
// Snapshots per-group compare results of one row and walks them
// chunk by chunk to find the lowest qualifying insertion point.
module scan_result_collector #(
  parameter int NUM_GROUPS     = 32,
  parameter int CHUNK          = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int GROUP_ADR_BITS = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  scan_result_collector_if.slave bus
);
  localparam int NCH = NUM_GROUPS / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] SNAP   = 3'd2;
  localparam logic [2:0] SCAN   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]                state;
  logic [CW-1:0]             cnt;
  logic [KW-1:0]             k;
  logic [2*NUM_GROUPS-1:0]   sh_rs;
  logic [NUM_GROUPS-1:0]     sh_ov;
  logic [NUM_GROUPS-1:0]     sh_st;
  logic                      valid_q;
  logic [GROUP_ADR_BITS-1:0] idx_q;
  logic                      found_q;
  logic                      end_q;
  logic                      rf_q;
  logic                      busy_q;
  logic                      ovr_q;

  logic [NUM_GROUPS-1:0]     qual;
  logic [NUM_GROUPS-1:0]     eq;
  logic [CHUNK-1:0]          chunk_q;
  logic                      hit;
  logic [GROUP_ADR_BITS-1:0] hit_idx;
  logic                      handshake;

  always_comb begin
    qual = '0;
    eq   = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      qual[g] = sh_ov[g] & ~sh_st[g]
              & (sh_rs[2*g+1] | sh_rs[2*g]);
      eq[g]   = sh_rs[2*g+1];
    end
  end

  assign chunk_q = qual[int'(k)*CHUNK +: CHUNK];

  // descending walk so the lowest set bit is the one left standing
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk_q[i]) begin
        hit     = 1'b1;
        hit_idx = GROUP_ADR_BITS'(int'(k) * CHUNK + i);
      end
    end
  end

  assign handshake = (state == DONE) && bus.rsltReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      k       <= '0;
      sh_rs   <= '0;
      sh_ov   <= '0;
      sh_st   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      found_q <= 1'b0;
      end_q   <= 1'b0;
      rf_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (bus.scanStart) begin
        ovr_q   <= (state != IDLE) && !handshake;
        state   <= SETTLE;
        cnt     <= CW'(SETTLE_CYCLES - 1);
        valid_q <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          SETTLE: begin
            if (cnt == '0) state <= SNAP;
            else           cnt   <= cnt - CW'(1);
          end
          SNAP: begin
            sh_rs <= bus.grpRslt;
            sh_ov <= bus.overTgt;
            sh_st <= bus.stopI;
            rf_q  <= |bus.rowFullI;
            k     <= '0;
            state <= SCAN;
          end
          SCAN: begin
            if (hit) begin
              idx_q   <= hit_idx;
              found_q <= eq[hit_idx];
              end_q   <= 1'b0;
              valid_q <= 1'b1;
              state   <= DONE;
            end else if (k == KW'(NCH - 1)) begin
              idx_q   <= '0;
              found_q <= 1'b0;
              end_q   <= 1'b1;
              valid_q <= 1'b1;
              state   <= DONE;
            end else begin
              k <= k + KW'(1);
            end
          end
          DONE: begin
            if (bus.rsltReady) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rsltValid = valid_q;
  assign bus.rsltIndex = idx_q;
  assign bus.rsltFound = found_q;
  assign bus.rsltEnd   = end_q;
  assign bus.rowFullO  = rf_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_scan_result_collector.sv
// Directed bench for scan_result_collector with a cycle-level
// reference model checked on every falling edge.
module tb_scan_result_collector;
  localparam int NG  = 32;
  localparam int CH  = 8;
  localparam int S   = 2;
  localparam int NCH = NG / CH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  scan_result_collector_if #(.NUM_GROUPS(NG), .GROUP_ADR_BITS(5)) bus();

  scan_result_collector #(
    .NUM_GROUPS(NG), .CHUNK(CH), .SETTLE_CYCLES(S), .GROUP_ADR_BITS(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  bit m_valid = 0, m_busy = 0, m_ovr = 0;
  bit m_found = 0, m_end = 0, m_rf = 0;
  int m_idx = 0;
  int snap_at = -1, deliver_at = -1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // reference: timing from edge arithmetic, result from a linear search
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_busy = 0; m_ovr = 0;
      m_idx = 0; m_found = 0; m_end = 0; m_rf = 0;
      snap_at = -1; deliver_at = -1;
    end else begin
      bit ov_n;
      ov_n = 0;
      if (bus.scanStart) begin
        ov_n = m_busy && !(m_valid && bus.rsltReady);
        m_valid = 0;
        m_busy = 1;
        snap_at = cyc + S + 1;
        deliver_at = -1;
      end else begin
        if (m_valid && bus.rsltReady) begin
          m_valid = 0;
          m_busy = 0;
        end
        if (cyc == snap_at) begin
          int ck;
          m_idx = 0; m_found = 0; m_end = 1; ck = NCH - 1;
          for (int g = 0; g < NG; g++) begin
            if (bus.overTgt[g] && !bus.stopI[g] &&
                bus.grpRslt[2*g +: 2] != 2'b00) begin
              m_idx = g;
              m_found = bus.grpRslt[2*g+1];
              m_end = 0;
              ck = g / CH;
              break;
            end
          end
          m_rf = |bus.rowFullI;
          deliver_at = cyc + 1 + ck;
          snap_at = -1;
        end
        if (cyc == deliver_at) begin
          m_valid = 1;
          deliver_at = -1;
        end
      end
      m_ovr = ov_n;
    end
  end

  always @(negedge clk) begin
    chk("valid", 32'(bus.rsltValid), 32'(m_valid));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
    if (m_valid) begin
      chk("index", 32'(bus.rsltIndex), 32'(m_idx));
      chk("found", 32'(bus.rsltFound), 32'(m_found));
      chk("end", 32'(bus.rsltEnd), 32'(m_end));
      chk("rowfull", 32'(bus.rowFullO), 32'(m_rf));
    end
  end

  task automatic clear_vec();
    bus.grpRslt = '0;
    bus.overTgt = '0;
    bus.stopI = '0;
    bus.rowFullI = '0;
  endtask

  task automatic set_grp(int g, logic [1:0] r);
    bus.overTgt[g] = 1'b1;
    bus.grpRslt[2*g +: 2] = r;
  endtask

  task automatic start_scan();
    @(posedge clk); #2;
    bus.scanStart = 1'b1;
    @(posedge clk); #1;
    t0 = cyc - 1;
    #1 bus.scanStart = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsltValid) begin
        lat = cyc - 1 - t0;
        return;
      end
    end
  endtask

  task automatic expect_result(string tag, int lat_e, int idx_e,
                               bit fnd_e, bit end_e, bit rf_e);
    int lat;
    wait_valid(lat);
    chk({tag, "_latency"}, 32'(lat), 32'(lat_e));
    chk({tag, "_index"}, 32'(bus.rsltIndex), 32'(idx_e));
    chk({tag, "_found"}, 32'(bus.rsltFound), 32'(fnd_e));
    chk({tag, "_end"}, 32'(bus.rsltEnd), 32'(end_e));
    chk({tag, "_rowfull"}, 32'(bus.rowFullO), 32'(rf_e));
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_valid"}, 32'(bus.rsltValid), 0);
    chk({tag, "_index"}, 32'(bus.rsltIndex), 0);
    chk({tag, "_found"}, 32'(bus.rsltFound), 0);
    chk({tag, "_end"}, 32'(bus.rsltEnd), 0);
    chk({tag, "_rowfull"}, 32'(bus.rowFullO), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_overrun"}, 32'(bus.overrun), 0);
  endtask

  initial begin
    bit saw;
    bus.scanStart = 1'b0;
    bus.rsltReady = 1'b1;
    clear_vec();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    set_grp(1, 2'b00);
    set_grp(3, 2'b01);
    set_grp(5, 2'b10);
    start_scan();
    expect_result("scan1", 4, 3, 0, 0, 0);

    bus.grpRslt[7:6] = 2'b00;
    start_scan();
    expect_result("scan2", 4, 5, 1, 0, 0);

    clear_vec();
    set_grp(30, 2'b01);
    start_scan();
    expect_result("g30", 7, 30, 0, 0, 0);
    bus.stopI[30] = 1'b1;
    start_scan();
    expect_result("nohit", 7, 0, 0, 1, 0);

    clear_vec();
    set_grp(9, 2'b10);
    bus.rsltReady = 1'b0;
    start_scan();
    expect_result("hold", 5, 9, 1, 0, 0);
    repeat (10) @(negedge clk);
    chk("hold_valid", 32'(bus.rsltValid), 1);
    chk("hold_index", 32'(bus.rsltIndex), 9);
    @(posedge clk); #2 bus.rsltReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_valid", 32'(bus.rsltValid), 0);
    chk("release_busy", 32'(bus.busy), 0);

    clear_vec();
    set_grp(30, 2'b01);
    start_scan();
    repeat (3) @(posedge clk);
    #2;
    clear_vec();
    set_grp(12, 2'b10);
    start_scan();
    @(negedge clk);
    chk("overrun_pulse", 32'(bus.overrun), 1);
    expect_result("restart", 5, 12, 1, 0, 0);

    clear_vec();
    set_grp(1, 2'b10);
    bus.rsltReady = 1'b0;
    start_scan();
    expect_result("done_a", 4, 1, 1, 0, 0);
    @(posedge clk); #2;
    bus.rsltReady = 1'b1;
    bus.scanStart = 1'b1;
    @(posedge clk); #1;
    t0 = cyc - 1;
    #1 bus.scanStart = 1'b0;
    @(negedge clk);
    chk("done_restart_overrun", 32'(bus.overrun), 0);
    chk("done_restart_valid", 32'(bus.rsltValid), 0);
    expect_result("done_b", 4, 1, 1, 0, 0);

    start_scan();
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsltValid) saw = 1;
    end
    chk("no_valid_after_reset", 32'(saw), 0);

    clear_vec();
    set_grp(1, 2'b10);
    bus.rowFullI[31] = 1'b1;
    start_scan();
    expect_result("rowfull", 4, 1, 1, 0, 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
